alu_74181_seq: RTL
==================

Name: alu_74181_seq

Overview:
- Parametrised, multi-cycle successor to the fixed two-slice 74181 ALU datapath.
- Operands of WIDTH bits are processed by one shared alu_74181 slice, one nibble per clock, LSB first, with a registered ripple carry between nibbles.
- Adds a start/busy/done handshake, a registered result, aggregate flags and an accumulate mode (A operand taken from the previous result).
- Sits behind the SPI register file: config registers drive the operands and start; status registers read back the result and flags.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4, derived nibble count; not overridable.
- CNT_W, clog2(NIB)+1, derived nibble-counter width.

Ports:
- clk  input  1  system clock.
- rstb  input  1  reset; asynchronous, active-low.
- ena  input  1  clock enable; when low all state holds.
- start  input  1  single-cycle request; accepted only in IDLE or DONE.
- acc  input  1  sampled with start; 1 = use the current result register as the A operand.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- s  input  4  74181 function select.
- m  input  1  mode: 1 = logic, 0 = arithmetic.
- cn  input  1  carry-in to nibble 0, alu_74181 polarity (1 = no carry in arithmetic mode).
- busy  output  1  high while nibbles are being processed.
- done  output  1  one-cycle pulse when the result becomes valid.
- f  output  WIDTH  result register.
- cn_out  output  1  cn4 of the last nibble, same polarity as cn.
- equal  output  1  AND of all per-nibble equal outputs (F all ones).
- zero  output  1  high when f == 0.

Behaviour:
- Reset (rstb low, asynchronous): state IDLE, busy=0, done=0, f=0, cn_out=1, equal=0, zero=1, nibble counter=0, operand latches=0.
- ena low: no register updates, including the done pulse; the FSM resumes when ena returns high.
- State IDLE:
  - start=1 latches a (or f when acc=1), b, s, m and cn.
  - Sets the carry register to cn, clears the counter and goes to BUSY.
  - busy rises on the next cycle.
- State BUSY, each cycle, for nibble k = counter:
  - The slice computes on A[4k+3:4k], B[4k+3:4k], s, m and the carry register.
  - It writes the F nibble into the shadow result at [4k+3:4k], stores cn4 into the carry register, and ANDs the slice equal output into the equal accumulator (seeded to 1 at start).
  - The counter increments; when k == NIB-1, the next state is DONE.
- Carry chaining: cn4 feeds the next nibble's cn unchanged, exactly as in the two-slice chain; in logic mode (m=1) the carry is still propagated but does not affect F.
- State DONE, one cycle:
  - f, cn_out and equal load from the shadow registers; zero is recomputed from the new f.
  - done=1 and busy=0; the next state is IDLE.
- Latency: start accepted at cycle 0, done high at cycle NIB+1. Throughput is one operation per NIB+2 cycles (DONE also accepts start, giving NIB+1).
- start while BUSY is ignored; it is not queued.
- start in DONE is accepted and goes straight to BUSY. The result being written that cycle is the A source when acc=1.
- Inputs a, b, s, m, cn may change freely after the start cycle; only the latched copies are used.
- f, cn_out, equal and zero hold their values between operations and change only in DONE.
- Reset during BUSY aborts the operation; outputs return to their reset values and no done is produced.
- WIDTH=4 case: NIB=1, a single BUSY cycle.

Test Plan:
- WIDTH=16, a=0x00FF, b=0x0001, s=1001, m=0, cn=1, start -> done at cycle 5, f=0x0100, cn_out=1, zero=0, busy high for cycles 1-4.
- a=0xFFFF, b=0x0001, s=1001, m=0, cn=1 -> f=0x0000, cn_out=0 (carry out), zero=1.
- Logic: s=0110, m=1, a=0xA5A5, b=0x0FF0 -> f=0xAA55. Then s=0000, m=1, a=0x0000 -> f=0xFFFF, equal=1.
- Accumulate: f=0x0100 from the first test, then start with acc=1, b=0x0001, s=1001, m=0, cn=1 -> f=0x0101. Input a is ignored even if driven to 0xFFFF.
- Handshake: a second start pulse at cycle 2 of BUSY is ignored (single done, f unchanged from the first op). Holding ena low for 3 cycles mid-BUSY delays done by exactly 3 cycles with the same f.
- Reset mid-op: assert rstb low at cycle 3 of BUSY -> busy=0, f=0, cn_out=1, zero=1 immediately, no done. A fresh op after release completes normally.

Source files
------------

// File: rtl/alu_74181_seq.sv
// Multi-cycle WIDTH-bit ALU: one 74181-style slice processes a nibble per clock,
// LSB first, with a registered ripple carry and a start/busy/done handshake.

module alu_74181 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [3:0] s,
  input  logic       m,
  input  logic       cn,
  output logic [3:0] f,
  output logic       cn4,
  output logic       equal
);
  logic [3:0] t1;
  logic [3:0] t2;
  logic [4:0] c;

  // t1/t2 are the two selected operands being summed; t2 is always a subset of t1,
  // so the generate term is t2 and the propagate term is t1.
  always_comb begin
    t1 = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    t2 = (a & ~b & {4{s[2]}}) | (a & b & {4{s[3]}});
    c  = '0;
    c[0] = ~cn;
    for (int i = 0; i < 4; i++) begin
      c[i+1] = t2[i] | (t1[i] & c[i]);
    end
    f = t1 ^ t2 ^ (m ? 4'hF : c[3:0]);
  end

  assign cn4   = ~c[4];
  assign equal = &f;
endmodule

module alu_74181_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             cn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] f,
  output logic             cn_out,
  output logic             equal,
  output logic             zero
);
  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = $clog2(NIB) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [3:0]       s_q;
  logic             m_q;
  logic             carry_q;
  logic             eq_acc;
  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] shadow_nxt;
  logic [3:0]       slice_f;
  logic             slice_cn4;
  logic             slice_eq;

  alu_74181 u_slice (
    .a     (a_q[{cnt, 2'b00} +: 4]),
    .b     (b_q[{cnt, 2'b00} +: 4]),
    .s     (s_q),
    .m     (m_q),
    .cn    (carry_q),
    .f     (slice_f),
    .cn4   (slice_cn4),
    .equal (slice_eq)
  );

  // The last nibble's result is merged here so f is already valid in the DONE cycle.
  always_comb begin
    shadow_nxt = shadow;
    shadow_nxt[{cnt, 2'b00} +: 4] = slice_f;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b1;
      eq_acc  <= 1'b1;
      shadow  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      f       <= '0;
      cn_out  <= 1'b1;
      equal   <= 1'b0;
      zero    <= 1'b1;
    end else if (ena) begin
      case (state)
        IDLE, DONE: begin
          done  <= 1'b0;
          state <= IDLE;
          if (start) begin
            // In DONE, f already holds the result just produced, so chaining works.
            a_q     <= acc ? f : a;
            b_q     <= b;
            s_q     <= s;
            m_q     <= m;
            carry_q <= cn;
            cnt     <= '0;
            eq_acc  <= 1'b1;
            busy    <= 1'b1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          shadow  <= shadow_nxt;
          carry_q <= slice_cn4;
          eq_acc  <= eq_acc & slice_eq;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            f      <= shadow_nxt;
            cn_out <= slice_cn4;
            equal  <= eq_acc & slice_eq;
            zero   <= (shadow_nxt == '0);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
